// File: rtl/arp_receive.sv
// arp_receive: parses ARP frames, qualifies them against local addresses and issues replies/cache updates
module arp_receive (
  input  logic        clk_user_i,
  input  logic        reset_i,
  input  logic [31:0] our_ip_address,
  input  logic [47:0] our_mac_address,
  input  logic [31:0] rx_arp_data_i,
  input  logic        rx_arp_data_vld_i,
  input  logic        rx_arp_data_tlast_i,
  output logic        reply_send_en,
  output logic [47:0] reply_send_mac_addr,
  output logic [31:0] reply_send_ip_addr,
  input  logic        reply_ready,
  output logic        arp_reply_vld_o,
  output logic [47:0] arp_reply_mac_o,
  output logic [31:0] arp_reply_ip_o,
  output logic [15:0] rx_arp_drop_cnt_o
);
  typedef enum logic [1:0] {IDLE, HDR, PAD, DROP} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dst_hi_q;
  logic [15:0] tpa_hi_q;
  logic        req_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic        send_en_q, send_en_d;
  logic [47:0] send_mac_q;
  logic [31:0] send_ip_q;
  logic        vld_q;
  logic [47:0] rmac_q;
  logic [31:0] rip_q;
  logic [15:0] drop_q, drop_d;
  logic        beat, fin, bad, qual, load, discard;
  logic [47:0] dst_mac;
  logic [31:0] tpa;
  logic [15:0] oper;
  assign dst_mac = {dst_hi_q, rx_arp_data_i[31:16]};
  assign tpa     = {tpa_hi_q, rx_arp_data_i[31:16]};
  assign oper    = rx_arp_data_i[31:16];
  // Header checks at the beat carrying each field, frame verdict at tlast, next-state and counters
  always_comb begin
    beat = rx_arp_data_vld_i;
    fin = beat && rx_arp_data_tlast_i;
    bad = state_q == HDR && (
      (cnt_q == 4'd1 && dst_mac != our_mac_address && dst_mac != 48'hFFFF_FFFF_FFFF) ||
      (cnt_q == 4'd3 && rx_arp_data_i != 32'h0806_0001) ||
      (cnt_q == 4'd4 && rx_arp_data_i != 32'h0800_0604) ||
      (cnt_q == 4'd5 && oper != 16'd1 && oper != 16'd2) ||
      (cnt_q == 4'd10 && tpa != our_ip_address));
    qual = fin && ((state_q == HDR && cnt_q == 4'd10 && !bad) || state_q == PAD);
    load = qual && req_q && !send_en_q && reply_ready;
    discard = (fin && !qual) || (qual && req_q && !load);
    cnt_d = !beat ? cnt_q : fin ? 4'd0 : cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1;
    state_d = !beat ? state_q : fin ? IDLE : state_q == IDLE ? HDR :
              state_q == HDR ? (bad ? DROP : cnt_q == 4'd10 ? PAD : HDR) : state_q;
    send_en_d = load || (send_en_q && !reply_ready);
    drop_d = discard && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end
  // State, field captures and output registers; send addresses only move when a request is loaded
  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dst_hi_q   <= '0;
      tpa_hi_q   <= '0;
      req_q      <= 1'b0;
      sha_q      <= '0;
      spa_q      <= '0;
      send_en_q  <= 1'b0;
      send_mac_q <= '0;
      send_ip_q  <= '0;
      vld_q      <= 1'b0;
      rmac_q     <= '0;
      rip_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      send_en_q <= send_en_d;
      drop_q    <= drop_d;
      vld_q     <= qual;
      if (beat && state_q == IDLE) dst_hi_q <= rx_arp_data_i;
      if (beat && state_q == HDR && cnt_q == 4'd5) {req_q, sha_q[47:32]} <= {oper == 16'd1, rx_arp_data_i[15:0]};
      if (beat && state_q == HDR && cnt_q == 4'd6) sha_q[31:0] <= rx_arp_data_i;
      if (beat && state_q == HDR && cnt_q == 4'd7) spa_q <= rx_arp_data_i;
      if (beat && state_q == HDR && cnt_q == 4'd9) tpa_hi_q <= rx_arp_data_i[15:0];
      if (qual) {rmac_q, rip_q} <= {sha_q, spa_q};
      if (load) {send_mac_q, send_ip_q} <= {sha_q, spa_q};
    end
  end
  assign reply_send_en       = send_en_q;
  assign reply_send_mac_addr = send_mac_q;
  assign reply_send_ip_addr  = send_ip_q;
  assign arp_reply_vld_o     = vld_q;
  assign arp_reply_mac_o     = rmac_q;
  assign arp_reply_ip_o      = rip_q;
  assign rx_arp_drop_cnt_o   = drop_q;
endmodule
